// File: rtl/tag_match_pkg.sv
// Shared types and sizes for the 4-way tag store and its match encoder.
package tag_match_pkg;

    localparam int unsigned WAYS  = 4;
    localparam int unsigned WAY_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        UPDATE = 2'd2
    } state_e;

    // Parallel lookup result: hit way and lowest-index invalid way
    typedef struct packed {
        logic             hit;
        logic [WAY_W-1:0] hit_way;
        logic             free;
        logic [WAY_W-1:0] free_way;
    } match_t;

endpackage

// File: rtl/way_match_enc.sv
// Combinational compare of a request tag against all valid ways, plus
// lowest-index free-way encoder.
module way_match_enc
    import tag_match_pkg::*;
#(
    parameter int unsigned TAG_W = 8
) (
    input  logic [WAYS-1:0]            valid,
    input  logic [WAYS-1:0][TAG_W-1:0] tags,
    input  logic [TAG_W-1:0]           req_tag,
    output match_t                     match
);

    always_comb begin
        match = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (valid[w] && (tags[w] == req_tag)) begin
                match.hit     = 1'b1;
                match.hit_way = WAY_W'(w);
            end
            // First invalid way wins, so later ones must not overwrite it
            if (!valid[w] && !match.free) begin
                match.free     = 1'b1;
                match.free_way = WAY_W'(w);
            end
        end
    end

endmodule

// File: rtl/tag_match_4way.sv
// Tag store and lookup controller for one 4-way set; drives the touch
// interface of the matrix LRU and allocates free or LRU victim ways on a miss.
module tag_match_4way
    import tag_match_pkg::*;
#(
    parameter int unsigned TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ReqValid,
    input  logic [TAG_W-1:0] ReqTag,
    output logic             ReqReady,
    input  logic [WAY_W-1:0] LRUWay,
    output logic             Hit,
    output logic [WAY_W-1:0] LineIndex,
    output logic             RespValid,
    output logic             RespHit,
    output logic [WAY_W-1:0] RespWay,
    output logic             Evict,
    output logic [TAG_W-1:0] EvictTag
);

    state_e                     state_q, state_d;
    logic [WAYS-1:0]            valid_q;
    logic [WAYS-1:0][TAG_W-1:0] tag_q;
    logic [TAG_W-1:0]           req_tag_q;
    match_t                     match_c, match_q;
    logic [WAY_W-1:0]           victim_q;
    logic [WAY_W-1:0]           last_way_q;

    logic                       fire_c;
    logic                       full_c;
    logic [WAY_W-1:0]           touch_way_c;

    logic                       ready_d;
    logic                       touch_hit_d;
    logic [WAY_W-1:0]           line_index_d;
    logic                       resp_valid_d;
    logic                       resp_hit_d;
    logic [WAY_W-1:0]           resp_way_d;
    logic                       evict_d;
    logic [TAG_W-1:0]           evict_tag_d;

    way_match_enc #(.TAG_W(TAG_W)) u_enc (
        .valid   (valid_q),
        .tags    (tag_q),
        .req_tag (req_tag_q),
        .match   (match_c)
    );

    assign fire_c = ReqValid && ReqReady;
    assign full_c = !match_c.hit && !match_c.free;

    // Way touched and written by the UPDATE cycle, from the registered lookup
    assign touch_way_c = match_q.hit  ? match_q.hit_way  :
                         match_q.free ? match_q.free_way : victim_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next registered output values; outside UPDATE the
    // touch re-presents the last MRU way so the LRU order stays put
    always_comb begin
        state_d      = state_q;
        ready_d      = 1'b0;
        touch_hit_d  = 1'b1;
        line_index_d = last_way_q;
        resp_valid_d = 1'b0;
        resp_hit_d   = 1'b0;
        resp_way_d   = '0;
        evict_d      = 1'b0;
        evict_tag_d  = '0;
        case (state_q)
            IDLE: begin
                if (fire_c) begin
                    state_d = LOOKUP;
                end else begin
                    ready_d = 1'b1;
                end
            end
            LOOKUP: begin
                state_d      = UPDATE;
                resp_valid_d = 1'b1;
                resp_hit_d   = match_c.hit;
                resp_way_d   = match_c.hit  ? match_c.hit_way  :
                               match_c.free ? match_c.free_way : LRUWay;
                evict_d      = full_c;
                evict_tag_d  = full_c ? tag_q[LRUWay] : '0;
                touch_hit_d  = !full_c;
                line_index_d = resp_way_d;
            end
            UPDATE: begin
                state_d      = IDLE;
                ready_d      = 1'b1;
                line_index_d = touch_way_c;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ReqReady   <= 1'b1;
            Hit        <= 1'b1;
            LineIndex  <= '0;
            RespValid  <= 1'b0;
            RespHit    <= 1'b0;
            RespWay    <= '0;
            Evict      <= 1'b0;
            EvictTag   <= '0;
            valid_q    <= '0;
            tag_q      <= '0;
            req_tag_q  <= '0;
            match_q    <= '0;
            victim_q   <= '0;
            last_way_q <= '0;
        end else begin
            ReqReady  <= ready_d;
            Hit       <= touch_hit_d;
            LineIndex <= line_index_d;
            RespValid <= resp_valid_d;
            RespHit   <= resp_hit_d;
            RespWay   <= resp_way_d;
            Evict     <= evict_d;
            EvictTag  <= evict_tag_d;
            if ((state_q == IDLE) && fire_c) begin
                req_tag_q <= ReqTag;
            end
            if (state_q == LOOKUP) begin
                match_q  <= match_c;
                victim_q <= LRUWay;
            end
            // A hit never allocates, so duplicate tags cannot arise
            if (state_q == UPDATE) begin
                last_way_q <= touch_way_c;
                if (!match_q.hit) begin
                    valid_q[touch_way_c] <= 1'b1;
                    tag_q[touch_way_c]   <= req_tag_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_tag_match_4way.sv
// Bench for tag_match_4way with a behavioural LRU on the touch interface and
// a transaction-level reference model of the set.
module tb_tag_match_4way;

    logic       clk = 1'b0;
    logic       reset;
    logic       ReqValid;
    logic [7:0] ReqTag;
    logic       ReqReady;
    logic [1:0] LRUWay;
    logic       Hit;
    logic [1:0] LineIndex;
    logic       RespValid;
    logic       RespHit;
    logic [1:0] RespWay;
    logic       Evict;
    logic [7:0] EvictTag;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       hit;
        logic [1:0] way;
        logic       evict;
        logic [7:0] etag;
    } exp_t;

    tag_match_4way #(.TAG_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .ReqValid  (ReqValid),
        .ReqTag    (ReqTag),
        .ReqReady  (ReqReady),
        .LRUWay    (LRUWay),
        .Hit       (Hit),
        .LineIndex (LineIndex),
        .RespValid (RespValid),
        .RespHit   (RespHit),
        .RespWay   (RespWay),
        .Evict     (Evict),
        .EvictTag  (EvictTag)
    );

    always #5 clk = ~clk;

    // Stand-in LRU: recency list, LRU first, touched on every negedge
    int         lru_q[$] = '{0, 1, 2, 3};
    logic [1:0] lru_way  = 2'd0;
    assign LRUWay = lru_way;

    always @(negedge clk) begin
        int tw;
        if (reset) begin
            lru_q = '{0, 1, 2, 3};
        end else begin
            tw = Hit ? int'(LineIndex) : int'(lru_way);
            for (int i = 0; i < lru_q.size(); i++) begin
                if (lru_q[i] == tw) begin
                    lru_q.delete(i);
                    break;
                end
            end
            lru_q.push_back(tw);
        end
        lru_way = 2'(lru_q[0]);
    end

    // Reference model of the set contents and recency order
    logic       m_valid[4];
    logic [7:0] m_tag[4];
    int         m_order[$];

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 8'h00;
        end
        m_order = '{1, 2, 3, 0};
    endtask

    task automatic model_touch(input int w);
        for (int i = 0; i < m_order.size(); i++) begin
            if (m_order[i] == w) begin
                m_order.delete(i);
                break;
            end
        end
        m_order.push_back(w);
    endtask

    task automatic predict(input logic [7:0] t, output exp_t e);
        int w;
        w = -1;
        e = '{hit: 1'b0, way: 2'd0, evict: 1'b0, etag: 8'h00};
        for (int i = 0; i < 4; i++)
            if (m_valid[i] && m_tag[i] == t) w = i;
        if (w >= 0) begin
            e.hit = 1'b1;
        end else begin
            for (int i = 3; i >= 0; i--)
                if (!m_valid[i]) w = i;
            if (w < 0) begin
                w       = m_order[0];
                e.evict = 1'b1;
                e.etag  = m_tag[w];
            end
            m_valid[w] = 1'b1;
            m_tag[w]   = t;
        end
        e.way = 2'(w);
        model_touch(w);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && ReqReady !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        chk("ready_timeout", 32'(ReqReady), 32'(1));
    endtask

    task automatic check_resp(input exp_t e);
        chk("resp_valid", 32'(RespValid), 32'(1));
        chk("resp_hit",   32'(RespHit),   32'(e.hit));
        chk("resp_way",   32'(RespWay),   32'(e.way));
        chk("evict",      32'(Evict),     32'(e.evict));
        chk("evict_tag",  32'(EvictTag),  32'(e.etag));
        chk("touch_hit",  32'(Hit),       32'(!e.evict));
        chk("line_index", 32'(LineIndex), 32'(e.way));
    endtask

    task automatic check_after(input exp_t e);
        chk("resp_clear",  32'(RespValid), 32'(0));
        chk("ready_back",  32'(ReqReady),  32'(1));
        chk("idle_touch",  32'(Hit),       32'(1));
        chk("idle_index",  32'(LineIndex), 32'(e.way));
        chk("lru_way",     32'(LRUWay),    32'(m_order[0]));
    endtask

    // One full transaction starting from a point #1 after a posedge
    task automatic do_req(input logic [7:0] t);
        exp_t e;
        wait_ready();
        ReqValid = 1'b1;
        ReqTag   = t;
        predict(t, e);
        @(posedge clk);
        #1;
        ReqValid = 1'b0;
        ReqTag   = 8'(($urandom));
        chk("lookup_ready", 32'(ReqReady),  32'(0));
        chk("lookup_resp",  32'(RespValid), 32'(0));
        @(posedge clk);
        #1;
        check_resp(e);
        @(posedge clk);
        #1;
        check_after(e);
    endtask

    initial begin
        exp_t e1, e2;
        logic [7:0] pool [8];
        reset    = 1'b1;
        ReqValid = 1'b0;
        ReqTag   = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",     32'(ReqReady),  32'(1));
        chk("rst_hit",       32'(Hit),       32'(1));
        chk("rst_index",     32'(LineIndex), 32'(0));
        chk("rst_rvalid",    32'(RespValid), 32'(0));
        chk("rst_resp_hit",  32'(RespHit),   32'(0));
        chk("rst_resp_way",  32'(RespWay),   32'(0));
        chk("rst_evict",     32'(Evict),     32'(0));
        chk("rst_evict_tag", 32'(EvictTag),  32'(0));
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("first_idle_lru", 32'(LRUWay), 32'(1));

        // Fill, hit, then two LRU evictions
        do_req(8'h11);
        do_req(8'h22);
        do_req(8'h33);
        do_req(8'h44);
        do_req(8'h22);
        do_req(8'h55);
        do_req(8'h11);

        // Idle touches must leave the LRU order alone
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("idle_lru_stable", 32'(LRUWay), 32'(m_order[0]));
        end

        // Reset during LOOKUP with the set full
        wait_ready();
        ReqValid = 1'b1;
        ReqTag   = 8'h66;
        @(posedge clk);
        #1;
        ReqValid = 1'b0;
        reset    = 1'b1;
        chk("rst_lookup_rv", 32'(RespValid), 32'(0));
        @(posedge clk);
        #1;
        chk("rst_abort_rv", 32'(RespValid), 32'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("post_rst_rv", 32'(RespValid), 32'(0));
        end
        do_req(8'h22);

        // ReqValid held across four edges: accepts at k and k+3
        wait_ready();
        ReqValid = 1'b1;
        ReqTag   = 8'h77;
        predict(8'h77, e1);
        @(posedge clk);
        #1;
        chk("hold_ready_k1", 32'(ReqReady), 32'(0));
        @(posedge clk);
        #1;
        check_resp(e1);
        chk("hold_ready_k2", 32'(ReqReady), 32'(0));
        @(posedge clk);
        #1;
        chk("hold_ready_k3", 32'(ReqReady), 32'(1));
        predict(8'h77, e2);
        @(posedge clk);
        #1;
        ReqValid = 1'b0;
        chk("hold_refire", 32'(ReqReady), 32'(0));
        @(posedge clk);
        #1;
        check_resp(e2);
        chk("hold_same_way", 32'(RespWay), 32'(e1.way));
        @(posedge clk);
        #1;
        check_after(e2);

        // Random traffic over a small tag pool to mix hits, fills and evictions
        for (int i = 0; i < 8; i++) pool[i] = 8'(8'h90 + i * 3);
        for (int n = 0; n < 60; n++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
                chk("rand_idle_lru", 32'(LRUWay), 32'(m_order[0]));
            end
            do_req(pool[$urandom_range(0, 7)]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
